// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter sharing one pipelined Kogge-Stone adder among NREQ
// requesters with bounded lock bursts and owner-tag return routing.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_req_vld/lock/a/b/cin          per-requester op (packed k*WIDTH)
//   o_req_rdy                       one-hot grant
//   o_add_vld/a/b/cin               registered adder inputs
//   i_add_sum/cout                  adder result, LAT cycles later
//   o_rsp_vld/sum/cout              one-hot routed response
//   o_busy                          ops in flight or lock held
module ks_add_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int LAT      = 6,
  parameter int MAX_LOCK = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_vld,
  input  logic [NREQ-1:0]       i_req_lock,
  input  logic [NREQ*WIDTH-1:0] i_req_a,
  input  logic [NREQ*WIDTH-1:0] i_req_b,
  input  logic [NREQ-1:0]       i_req_cin,
  output logic [NREQ-1:0]       o_req_rdy,
  output logic                  o_add_vld,
  output logic [WIDTH-1:0]      o_add_a,
  output logic [WIDTH-1:0]      o_add_b,
  output logic                  o_add_cin,
  input  logic [WIDTH-1:0]      i_add_sum,
  input  logic                  i_add_cout,
  output logic [NREQ-1:0]       o_rsp_vld,
  output logic [WIDTH-1:0]      o_rsp_sum,
  output logic                  o_rsp_cout,
  output logic                  o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW = $clog2(LAT + 3);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_OK = (MAX_LOCK > 1);

  typedef enum logic {
    S_ARB,
    S_LOCK
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_nx;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic [IW-1:0]   w_gid;
  logic [IW-1:0]   w_k;
  logic            w_hs;
  logic [NREQ-1:0] w_rdy;
  logic [OW-1:0]   r_out;
  logic [LAT:0]    r_tv;
  logic [IW-1:0]   r_tid [LAT+1];

  // Grant select. Searching offsets high-to-low lets the
  // nearest valid requester after r_ptr win the last write.
  always_comb begin
    w_gid = '0;
    w_k   = '0;
    w_hs  = 1'b0;
    w_rdy = '0;
    if (r_state == S_LOCK) begin
      if (i_req_vld[r_owner]) begin
        w_gid = r_owner;
        w_hs  = 1'b1;
      end
    end else begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        w_k = IW'((int'(r_ptr) + i) % NREQ);
        if (i_req_vld[w_k]) begin
          w_gid = w_k;
          w_hs  = 1'b1;
        end
      end
    end
    w_rdy[w_gid] = w_hs;
  end

  assign o_req_rdy = w_rdy;

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    if (w_hs) begin
      w_ptr_nx = (w_gid == IW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
    end
    unique case (r_state)
      S_ARB: begin
        if (w_hs && i_req_lock[w_gid] && LOCK_OK) begin
          w_state_nx = S_LOCK;
          w_owner_nx = w_gid;
          w_cnt_nx   = CW'(1);
        end
      end
      S_LOCK: begin
        if (w_hs && i_req_lock[r_owner]
            && (r_cnt < CW'(MAX_LOCK - 1))) begin
          w_cnt_nx = r_cnt + 1'b1;
        end else begin
          // owner dropped lock, went idle, or hit the burst bound
          w_state_nx = S_ARB;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = S_ARB;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_owner <= w_owner_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_add_vld <= 1'b0;
      o_add_a   <= '0;
      o_add_b   <= '0;
      o_add_cin <= 1'b0;
    end else begin
      o_add_vld <= w_hs;
      if (w_hs) begin
        o_add_a   <= i_req_a[w_gid*WIDTH +: WIDTH];
        o_add_b   <= i_req_b[w_gid*WIDTH +: WIDTH];
        o_add_cin <= i_req_cin[w_gid];
      end
    end
  end

  // Stage j of the tag pipe is visible j+1 cycles after the
  // handshake, so stage LAT lines up with i_add_sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tv <= '0;
      for (int i = 0; i <= LAT; i++) r_tid[i] <= '0;
    end else begin
      r_tv     <= {r_tv[LAT-1:0], w_hs};
      r_tid[0] <= w_gid;
      for (int i = 1; i <= LAT; i++) r_tid[i] <= r_tid[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_vld  <= '0;
      o_rsp_sum  <= '0;
      o_rsp_cout <= 1'b0;
    end else begin
      o_rsp_vld <= '0;
      if (r_tv[LAT]) begin
        o_rsp_vld  <= NREQ'(1) << r_tid[LAT];
        o_rsp_sum  <= i_add_sum;
        o_rsp_cout <= i_add_cout;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out <= '0;
    end else begin
      unique case ({w_hs, |o_rsp_vld})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

  assign o_busy = (r_out != '0) | (r_state == S_LOCK);

endmodule

// File: tb/tb_ks_add_arbiter.sv
// Self-checking bench for ks_add_arbiter: directed scenarios plus
// random traffic against a scoreboard and a behavioural adder.
module tb_ks_add_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int LAT  = 6;
  localparam int MAXL = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   rvld, rlock, rcin;
  logic [W-1:0]   ra [N];
  logic [W-1:0]   rb [N];
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_rdy;
  logic           add_vld, add_cin, add_cout;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic [N-1:0]   rsp_vld;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout, busy;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = ra[k];
      req_b[k*W +: W] = rb[k];
    end
  end

  ks_add_arbiter #(
    .NREQ(N), .WIDTH(W), .LAT(LAT), .MAX_LOCK(MAXL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(rvld), .i_req_lock(rlock),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(rcin),
    .o_req_rdy(req_rdy),
    .o_add_vld(add_vld), .o_add_a(add_a),
    .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_sum(add_sum), .i_add_cout(add_cout),
    .o_rsp_vld(rsp_vld), .o_rsp_sum(rsp_sum),
    .o_rsp_cout(rsp_cout), .o_busy(busy)
  );

  // behavioural pipelined adder, LAT cycles deep
  logic [W:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_sum  = apipe[LAT-1][W-1:0];
  assign add_cout = apipe[LAT-1][W];

  typedef struct {
    int         due;
    int         id;
    logic [W-1:0] sum;
    logic       cout;
  } rsp_t;

  rsp_t q[$];
  int   glog[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m_ptr, m_owner, m_cnt;
  bit   m_lock;
  bit   p_hs;
  logic [W-1:0] p_a, p_b, l_sum;
  logic p_cin, l_cout;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_lock) return rvld[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++)
      if (rvld[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 0;
    p_hs = 0; p_a = '0; p_b = '0; p_cin = 0;
    l_sum = '0; l_cout = 0;
  endtask

  task automatic cycle();
    int g;
    logic [W:0] s;
    rsp_t e;
    @(negedge clk);
    g = model_grant();
    chk("rdy", req_rdy, (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("busy", busy, (q.size() != 0 || m_lock) ? 1 : 0);
    chk("add_vld", add_vld, p_hs);
    chk("add_a", add_a, p_a);
    chk("add_b", add_b, p_b);
    chk("add_cin", add_cin, p_cin);
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      l_sum = e.sum;
      l_cout = e.cout;
      chk("rsp_vld", rsp_vld, 64'(1 << e.id));
    end else begin
      chk("rsp_idle", rsp_vld, 0);
    end
    chk("rsp_sum", rsp_sum, l_sum);
    chk("rsp_cout", rsp_cout, l_cout);
    p_hs = (g >= 0);
    if (g >= 0) begin
      s = {1'b0, ra[g]} + {1'b0, rb[g]} + (W+1)'(rcin[g]);
      e.due = cyc + LAT + 2;
      e.id = g;
      e.sum = s[W-1:0];
      e.cout = s[W];
      q.push_back(e);
      glog.push_back(g);
      p_a = ra[g]; p_b = rb[g]; p_cin = rcin[g];
      m_ptr = (g + 1) % N;
      if (!m_lock) begin
        if (rlock[g] && MAXL > 1) begin
          m_lock = 1; m_owner = g; m_cnt = 1;
        end
      end else begin
        m_cnt++;
        if (!rlock[g] || m_cnt >= MAXL) m_lock = 0;
      end
    end else if (m_lock) begin
      m_lock = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    rvld = '0; rlock = '0;
    repeat (n) cycle();
  endtask

  task automatic set_req(int k, bit l, logic [W-1:0] a,
                         logic [W-1:0] b, bit c);
    rvld[k] = 1'b1; rlock[k] = l; ra[k] = a; rb[k] = b; rcin[k] = c;
  endtask

  task automatic do_reset();
    rvld = '0; rlock = '0;
    rst_n = 1'b0;
    model_clear();
    #2;
    chk("rst_add_vld", add_vld, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst_n = 1'b1;
  endtask

  task automatic chk_log(string tag, int exp[]);
    chk({tag, "_len"}, glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk(tag, glog[i], exp[i]);
  endtask

  initial begin
    int e3[], e1[], e5[], e4[];
    rvld = '0; rlock = '0; rcin = '0;
    for (int k = 0; k < N; k++) begin ra[k] = '0; rb[k] = '0; end
    rst_n = 1'b0;
    do_reset();
    idle(2);

    // fairness: all four valid for 8 cycles
    glog.delete();
    for (int k = 0; k < N; k++)
      set_req(k, 0, 32'h1000 * (k + 1), 32'h11 * k, k[0]);
    repeat (8) cycle();
    idle(10);
    e3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("fair", e3);

    // single op on requester 2
    glog.delete();
    set_req(2, 0, 32'h5, 32'h3, 0);
    cycle();
    idle(9);
    e1 = '{2};
    chk_log("single", e1);
    chk("single_sum", rsp_sum, 32'h8);
    chk("single_cout", rsp_cout, 0);

    // wrap and carry on requester 0
    set_req(0, 0, 32'hFFFF_FFFF, 32'h1, 0);
    cycle();
    set_req(0, 0, 32'h7FFF_FFFF, 32'h0, 1);
    cycle();
    idle(10);
    chk("carry_sum", rsp_sum, 32'h8000_0000);
    chk("carry_cout", rsp_cout, 0);

    // pointer wrap with sparse requests
    glog.delete();
    set_req(3, 0, 32'h33, 32'h44, 1);
    cycle();
    rvld = '0;
    set_req(0, 0, 32'hABCD, 32'h1, 0);
    cycle();
    idle(10);
    e5 = '{3, 0};
    chk_log("sparse", e5);

    // lock burst bounded at MAX_LOCK
    glog.delete();
    set_req(0, 0, 32'hA0, 32'h1, 0);
    set_req(1, 1, 32'hB0, 32'h2, 1);
    set_req(2, 0, 32'hC0, 32'h3, 0);
    repeat (6) cycle();
    idle(12);
    e4 = '{1, 1, 1, 1, 2, 0};
    chk_log("lock", e4);

    // reset while three ops are in flight
    for (int k = 0; k < N; k++)
      set_req(k, 0, 32'hDEAD_0000 + k, 32'h100, 0);
    repeat (3) cycle();
    idle(1);
    do_reset();
    glog.delete();
    for (int k = 0; k < N; k++)
      set_req(k, 0, 32'h77 + k, 32'h9, 1);
    cycle();
    chk("post_rst_grant", glog[0], 0);
    idle(12);
    chk("post_rst_busy", busy, 0);

    // random traffic
    for (int t = 0; t < 300; t++) begin
      rvld = 4'($urandom);
      rlock = 4'($urandom) & 4'($urandom);
      rcin = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        ra[k] = (t % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
        rb[k] = $urandom;
      end
      cycle();
    end
    idle(14);
    chk("drain_q", q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
